seq_wide_adder: RTL
===================

SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the slice width in bits (N >= 1).
REQ-002 The block SHALL have parameter M, default 4, giving the number of slices (M >= 1); operand width W = N*M.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, W bits: first operand, captured on the accepted start edge.
REQ-007 The block SHALL have port b, input, W bits: second operand, captured on the accepted start edge.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port done_tick, output, 1 bit: one-cycle pulse when a result is complete.
REQ-010 The block SHALL have port sum, output, W bits: registered result, (a+b) mod 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out of the full W-bit addition.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, OP and DONE, and SHALL be Moore for ready and done_tick.
REQ-013 In IDLE with start=1 at an edge, the block SHALL load a and b into operand shift registers, clear the carry register, clear the slice counter, and go to OP.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-015 Each OP edge SHALL compute {1'b0,a_reg[N-1:0]} + {1'b0,b_reg[N-1:0]} + carry_reg as N+1 bits.
REQ-016 On that edge, bits [N-1:0] SHALL shift into the MSB end of the result shift register, bit N SHALL become carry_reg, both operand registers SHALL shift right by N, and the counter SHALL increment.
REQ-017 On the M-th OP edge (counter = M-1), the block SHALL load sum with the completed result and cout with the final slice carry, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle with done_tick=1; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge 0, sum and cout SHALL update at edge M, done_tick SHALL be high between edges M and M+1, and ready SHALL be high again after edge M+1.
REQ-020 sum and cout SHALL hold the previous result throughout OP and DONE, and SHALL change only on the edge defined in REQ-017.
REQ-021 start SHALL be ignored in OP and DONE, and changes to a and b after the accepted start edge SHALL NOT affect the result.
REQ-022 start held high continuously SHALL begin a new operation on every IDLE edge, giving one result every M+2 cycles.
REQ-023 With M=1, the block SHALL visit OP for one edge and produce the result as a single N-bit add.
REQ-024 The slice counter SHALL be ceil(log2(M))+1 bits wide, or wider, and SHALL never wrap during an operation.

Reset
REQ-025 While reset=1, the block SHALL force the FSM to IDLE and clear the operand, result, carry and counter registers immediately, independent of clk.
REQ-026 After reset, outputs SHALL be ready=1, done_tick=0, sum=0 and cout=0.
REQ-027 Reset asserted mid-OP or in DONE SHALL abort the operation with no done_tick; the first start after reset release SHALL complete normally.

Verification (N=4, M=4, W=16)
REQ-028 The bench SHALL check: reset pulse -> ready=1, done_tick=0, sum=0x0000, cout=0.
REQ-029 The bench SHALL check: a=0x1234, b=0x4321, start for 1 cycle -> sum=0x5555, cout=0; done_tick high only in the cycle after edge 4; ready=1 after edge 5.
REQ-030 The bench SHALL check: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1 (carry ripples through all 4 slices).
REQ-031 The bench SHALL check: start with a=0x8000, b=0x8000, then start=1 with a=0x0001, b=0x0001 during OP -> sum=0x0000, cout=1; one done_tick only.
REQ-032 The bench SHALL check: reset asserted after the 2nd OP edge of a=0x00FF, b=0x00FF -> no done_tick, sum=0, ready=1; a following start with a=0x00FF, b=0x00FF -> sum=0x01FE, cout=0.
REQ-033 The bench SHALL check: start held high with 100 random operand pairs -> results match (a+b) as 17 bits, each done_tick spaced 6 cycles apart, and sum is stable between updates.

Source files
------------

// File: rtl/seq_wide_adder.sv
// -----------------------------------------------------------------------------
// seq_wide_adder
//
// Adds two W-bit operands (W = N*M) one N-bit slice per clock, least
// significant slice first, rippling the slice carry through a one-bit
// register.
//
// A three-state Moore FSM sequences the operation:
//   IDLE -> OP (M edges) -> DONE (one cycle) -> IDLE
//
// With start accepted at edge 0:
//   - sum and cout update at edge M
//   - done_tick is high between edges M and M+1
//   - ready is high again after edge M+1
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   reset      : asynchronous, active-high; returns to IDLE and clears all
//                registers, including sum and cout
//   start      : begin an addition; sampled only in IDLE
//   a, b       : W-bit operands, captured on the accepted start edge
//   ready      : high only in IDLE
//   done_tick  : one-cycle pulse while in DONE
//   sum        : registered (a+b) mod 2^W; holds the previous result until
//                the last OP edge
//   cout       : registered carry-out of the full W-bit addition
// -----------------------------------------------------------------------------
module seq_wide_adder #(
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N*M-1:0] a,
   input  logic [N*M-1:0] b,
   output logic           ready,
   output logic           done_tick,
   output logic [N*M-1:0] sum,
   output logic           cout
);

   localparam int W  = N * M;
   // One spare bit beyond what is needed to count to M-1, so the counter
   // can never wrap within an operation.
   localparam int CW = $clog2(M) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;

   logic          load;
   logic          step;
   logic          last;

   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  res_reg;
   logic          carry_reg;
   logic [CW-1:0] cnt;

   logic [N:0]    slice;
   logic [W-1:0]  res_next;

   // N-bit add of the low slices plus the carry in, returned as N+1 bits so
   // the top bit is the slice carry-out.
   function automatic logic [N:0] slice_add(input logic [N-1:0] x,
                                            input logic [N-1:0] y,
                                            input logic         c);
      slice_add = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
   endfunction

   assign slice = slice_add(a_reg[N-1:0], b_reg[N-1:0], carry_reg);

   // The new slice enters at the MSB end, so after M steps the first slice
   // has reached the LSB end. Written as shift-and-or so it stays legal
   // when M = 1 (no older bits to keep).
   assign res_next = (res_reg >> N) | (W'(slice[N-1:0]) << (W - N));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done_tick  = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = OP;
            end
         end
         OP: begin
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done_tick  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
      end else if (load) begin
         a_reg     <= a;
         b_reg     <= b;
         carry_reg <= 1'b0;
         cnt       <= '0;
      end else if (step) begin
         a_reg     <= a_reg >> N;
         b_reg     <= b_reg >> N;
         res_reg   <= res_next;
         carry_reg <= slice[N];
         cnt       <= cnt + CW'(1);
         if (last) begin
            sum  <= res_next;
            cout <= slice[N];
         end
      end
   end

endmodule
